// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: control inputs and frame-clock outputs of the frame sequencer.
// master = APU side that drives tick/writes/acks; slave = the sequencer itself.
// Signals: tick, wr, wr_mode, wr_irq_inhibit, irq_ack -> sequencer;
//          quarter_frame, half_frame, frame_irq, step[2:0] <- sequencer.
interface frame_sequencer_if;
  logic       tick;
  logic       wr;
  logic       wr_mode;
  logic       wr_irq_inhibit;
  logic       irq_ack;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic [2:0] step;

  modport master (
    output tick, wr, wr_mode, wr_irq_inhibit, irq_ack,
    input  quarter_frame, half_frame, frame_irq, step
  );

  modport slave (
    input  tick, wr, wr_mode, wr_irq_inhibit, irq_ack,
    output quarter_frame, half_frame, frame_irq, step
  );
endinterface

// File: rtl/frame_sequencer.sv
// Purpose: APU frame counter producing quarter/half-frame clock pulses and the frame IRQ.
// Latency: pulses are registered, high for the one clk after the triggering tick edge.
// Backpressure: none; tick is a plain enable and writes/acks are single-cycle strobes.
// Ports: clk, rst (async, active-high); bus (frame_sequencer_if.slave):
//   tick/wr/wr_mode/wr_irq_inhibit/irq_ack in; quarter_frame/half_frame/frame_irq/step out.
module frame_sequencer #(
  parameter int STEP1       = 3729,
  parameter int STEP2       = 7457,
  parameter int STEP3       = 11186,
  parameter int STEP4       = 14915,
  parameter int STEP5       = 18641,
  parameter int WRITE_DELAY = 3
) (
  input  logic               clk,
  input  logic               rst,
  frame_sequencer_if.slave   bus
);

  localparam logic [14:0] S1 = 15'(STEP1);
  localparam logic [14:0] S2 = 15'(STEP2);
  localparam logic [14:0] S3 = 15'(STEP3);
  localparam logic [14:0] S4 = 15'(STEP4);
  localparam logic [14:0] S5 = 15'(STEP5);
  localparam int          DW = (WRITE_DELAY > 1) ? $clog2(WRITE_DELAY + 1) : 1;

  logic [14:0]   r_cnt;
  logic          r_mode;
  logic          r_inh;
  logic          r_pend;
  logic [DW-1:0] r_dly;
  logic          r_qf;
  logic          r_hf;
  logic          r_irq;
  logic [2:0]    r_step;

  logic [14:0]   w_cnt_inc;
  logic [14:0]   w_cnt_n;
  logic [2:0]    w_step_n;
  logic          w_q_n;
  logic          w_h_n;
  logic          w_set;
  logic          w_pend_n;
  logic [DW-1:0] w_dly_n;
  logic          w_restart;
  logic          w_rmode;

  always_comb begin
    w_cnt_inc = r_cnt + 15'd1;
    w_cnt_n   = r_cnt;
    w_step_n  = r_step;
    w_q_n     = 1'b0;
    w_h_n     = 1'b0;
    w_set     = 1'b0;
    w_pend_n  = r_pend;
    w_dly_n   = r_dly;
    w_restart = 1'b0;
    w_rmode   = r_mode;

    // A write always (re)arms the restart; only otherwise does a tick count it down.
    if (bus.wr) begin
      if (WRITE_DELAY == 0) begin
        w_restart = 1'b1;
        w_rmode   = bus.wr_mode;
      end else begin
        w_pend_n = 1'b1;
        w_dly_n  = DW'(WRITE_DELAY);
      end
    end else if (bus.tick && r_pend) begin
      if (r_dly == DW'(1)) begin
        w_restart = 1'b1;
        w_pend_n  = 1'b0;
      end else begin
        w_dly_n = r_dly - DW'(1);
      end
    end

    // Restart overrides any step event on the same edge. Sequencing uses the
    // mode that was in force before this edge's write latches.
    if (w_restart) begin
      w_cnt_n  = '0;
      w_step_n = 3'd0;
      w_q_n    = w_rmode;
      w_h_n    = w_rmode;
    end else if (bus.tick) begin
      w_cnt_n = w_cnt_inc;
      if (w_cnt_inc == S1) begin
        w_q_n    = 1'b1;
        w_step_n = 3'd1;
      end else if (w_cnt_inc == S2) begin
        w_q_n    = 1'b1;
        w_h_n    = 1'b1;
        w_step_n = 3'd2;
      end else if (w_cnt_inc == S3) begin
        w_q_n    = 1'b1;
        w_step_n = 3'd3;
      end else if ((w_cnt_inc == S4) && !r_mode) begin
        w_q_n    = 1'b1;
        w_h_n    = 1'b1;
        w_step_n = 3'd4;
        w_cnt_n  = '0;
        w_set    = !r_inh;
      end else if ((w_cnt_inc == S5) && r_mode) begin
        w_q_n    = 1'b1;
        w_h_n    = 1'b1;
        w_step_n = 3'd5;
        w_cnt_n  = '0;
      end else if (w_cnt_inc == 15'd0) begin
        // Natural 15-bit wrap (mode dropped to 4-step past STEP4): silent restart.
        w_step_n = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_mode <= 1'b0;
      r_inh  <= 1'b0;
      r_pend <= 1'b0;
      r_dly  <= '0;
      r_qf   <= 1'b0;
      r_hf   <= 1'b0;
      r_irq  <= 1'b0;
      r_step <= 3'd0;
    end else begin
      r_cnt  <= w_cnt_n;
      r_step <= w_step_n;
      r_qf   <= w_q_n;
      r_hf   <= w_h_n;
      r_pend <= w_pend_n;
      r_dly  <= w_dly_n;
      if (bus.wr) begin
        r_mode <= bus.wr_mode;
        r_inh  <= bus.wr_irq_inhibit;
      end
      // Setting beats any clear arriving on the same edge.
      if (w_set) begin
        r_irq <= 1'b1;
      end else if ((bus.wr && bus.wr_irq_inhibit) || bus.irq_ack) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign bus.quarter_frame = r_qf;
  assign bus.half_frame    = r_hf;
  assign bus.frame_irq     = r_irq;
  assign bus.step          = r_step;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic s_tick, s_wr, s_wm, s_wi, s_ack;

  frame_sequencer_if if0 ();
  frame_sequencer_if if1 ();

  assign if0.tick = s_tick;  assign if1.tick = s_tick;
  assign if0.wr = s_wr;      assign if1.wr = s_wr;
  assign if0.wr_mode = s_wm; assign if1.wr_mode = s_wm;
  assign if0.wr_irq_inhibit = s_wi; assign if1.wr_irq_inhibit = s_wi;
  assign if0.irq_ack = s_ack; assign if1.irq_ack = s_ack;

  frame_sequencer #(.WRITE_DELAY(3)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  frame_sequencer #(.WRITE_DELAY(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [5:0] w_o0, w_o1;
  assign w_o0 = {if0.quarter_frame, if0.half_frame, if0.frame_irq, if0.step};
  assign w_o1 = {if1.quarter_frame, if1.half_frame, if1.frame_irq, if1.step};

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // ---------------- behavioural model (one per DUT) ----------------
  int DLYV [2] = '{3, 0};
  int m_cnt [2];
  bit m_mode [2];
  bit m_inh [2];
  bit m_pend [2];
  int m_dly [2];
  bit m_irq [2];
  bit e_q [2];
  bit e_h [2];
  int e_step [2];

  function automatic int step_val(input int k);
    case (k)
      1: return 3729;
      2: return 7457;
      3: return 11186;
      4: return 14915;
      default: return 18641;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_mode[d] = 0; m_inh[d] = 0; m_pend[d] = 0; m_dly[d] = 0;
      m_irq[d] = 0; e_q[d] = 0; e_h[d] = 0; e_step[d] = 0;
    end
  endtask

  task automatic model_edge(input int d);
    bit om, oi, rs, rm, set;
    int n, k, last;
    om = m_mode[d]; oi = m_inh[d]; rs = 0; rm = m_mode[d]; set = 0;
    e_q[d] = 0; e_h[d] = 0;
    if (s_wr) begin
      m_mode[d] = s_wm; m_inh[d] = s_wi;
      if (DLYV[d] == 0) begin rs = 1; rm = s_wm; end
      else begin m_pend[d] = 1; m_dly[d] = DLYV[d]; end
    end else if (s_tick && m_pend[d]) begin
      if (m_dly[d] == 1) begin rs = 1; m_pend[d] = 0; end
      else m_dly[d] = m_dly[d] - 1;
    end
    if (rs) begin
      m_cnt[d] = 0; e_step[d] = 0; e_q[d] = rm; e_h[d] = rm;
    end else if (s_tick) begin
      n = m_cnt[d] + 1;
      k = 0;
      for (int s = 1; s <= 5; s++) if (step_val(s) == n) k = s;
      last = om ? 5 : 4;
      if (k != 0 && k <= last && !(om && k == 4)) begin
        e_q[d] = 1; e_h[d] = (k == 2 || k == last); e_step[d] = k;
        if (k == last && !om && !oi) set = 1;
      end
      if (k == last) m_cnt[d] = 0;
      else if (n == 32768) begin m_cnt[d] = 0; e_step[d] = 0; end
      else m_cnt[d] = n;
    end
    if (set) m_irq[d] = 1;
    else if ((s_wr && s_wi) || s_ack) m_irq[d] = 0;
  endtask

  function automatic int exp_pack(input int d);
    logic [5:0] v;
    v = {e_q[d], e_h[d], m_irq[d], 3'(e_step[d])};
    return int'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, want, $time);
    end
  endtask

  // Single compare process: every cycle, both DUTs against their models.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cycle_dut0", int'(w_o0), exp_pack(0));
      chk("cycle_dut1", int'(w_o1), exp_pack(1));
    end
  end

  task automatic cyc(input bit t, input bit w, input bit m, input bit ih, input bit ack);
    s_tick = t; s_wr = w; s_wm = m; s_wi = ih; s_ack = ack;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    s_tick = 0; s_wr = 0; s_wm = 0; s_wi = 0; s_ack = 0;
  endtask

  task automatic lit(input string nm, input int want);
    chk({nm, "_d0"}, int'(w_o0), want);
    chk({nm, "_d1"}, int'(w_o1), want);
  endtask

  int irq_hi, half_cnt, tk, first0, first1;
  bit reached;

  initial begin
    rst = 1'b1;
    s_tick = 0; s_wr = 0; s_wm = 0; s_wi = 0; s_ack = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    lit("reset", 0);
    rst = 1'b0;
    cmp_on = 1'b1;

    // Phase 1: mode 0 from reset, tick held high.
    for (int i = 1; i <= 29835; i++) begin
      cyc(1, 0, 0, 0, (i == 14915) || (i == 14920));
      if (i == 3728)  lit("t3728", 6'b000000);
      if (i == 3729)  lit("t3729", 6'b100001);
      if (i == 7457)  lit("t7457", 6'b110010);
      if (i == 11186) lit("t11186", 6'b100011);
      if (i == 14914) lit("t14914", 6'b000011);
      if (i == 14915) lit("t14915_ack_same", 6'b111100);
      if (i == 14916) lit("t14916", 6'b001100);
      if (i == 14920) lit("ack_clear", 6'b000100);
      if (i == 18644) lit("t18644", 6'b100001);
      if (i == 29830) lit("t29830", 6'b111100);
    end

    // Inhibit write clears the IRQ; a full mode-0 sequence then never sets it.
    cyc(1, 1, 0, 1, 0);
    chk("inh_clr_d0", int'(if0.frame_irq), 0);
    chk("inh_clr_d1", int'(if1.frame_irq), 0);
    irq_hi = 0; half_cnt = 0;
    for (int i = 0; i < 14930; i++) begin
      cyc(1, 0, 0, 0, 0);
      irq_hi += int'(if0.frame_irq) + int'(if1.frame_irq);
      half_cnt += int'(if0.half_frame);
    end
    chk("inh_irq_never", irq_hi, 0);
    chk("inh_halves_d0", half_cnt, 2);

    // Phase 2: two writes two ticks apart (mode 0 then mode 1, inhibit 0).
    cyc(1, 1, 0, 0, 0);
    chk("w1_nopulse_d0", int'(w_o0[5:4]), 0);
    chk("w1_nopulse_d1", int'(w_o1[5:4]), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("w2_nopulse_d0", int'(w_o0[5:4]), 0);
    chk("w2_restart_d1", int'(w_o1), 6'b110000);
    irq_hi = 0;
    for (int j = 1; j <= 18646; j++) begin
      cyc(1, 0, 0, 0, 0);
      irq_hi += int'(if0.frame_irq) + int'(if1.frame_irq);
      if (j == 2)     chk("m1_j2_d0", int'(w_o0[5:4]), 0);
      if (j == 3)     chk("m1_restart_d0", int'(w_o0), 6'b110000);
      if (j == 3732)  chk("m1_s1_d0", int'(w_o0), 6'b100001);
      if (j == 7460)  chk("m1_s2_d0", int'(w_o0), 6'b110010);
      if (j == 11189) chk("m1_s3_d0", int'(w_o0), 6'b100011);
      if (j == 14918) chk("m1_s4none_d0", int'(w_o0), 6'b000011);
      if (j == 18644) chk("m1_s5_d0", int'(w_o0), 6'b110101);
      if (j == 3729)  chk("m1_s1_d1", int'(w_o1), 6'b100001);
      if (j == 18641) chk("m1_s5_d1", int'(w_o1), 6'b110101);
    end
    chk("m1_irq_never", irq_hi, 0);

    // Phase 3: randomized traffic, model-checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end

    // Phase 4: run to cnt=5000, reset mid-sequence, then 1-of-4 ticks.
    reached = 0;
    for (int c = 0; c < 20000 && !reached; c++) begin
      cyc(1, 0, 0, 0, 0);
      reached = (m_cnt[0] == 5000);
    end
    chk("reach_cnt5000", int'(reached), 1);
    rst = 1'b1;
    model_reset();
    #1;
    lit("rst_mid", 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tk = 0; first0 = -1; first1 = -1;
    for (int c = 0; c < 15000; c++) begin
      cyc((c % 4) == 0, 0, 0, 0, 0);
      if ((c % 4) == 0) tk++;
      if (first0 < 0 && if0.quarter_frame) first0 = tk;
      if (first1 < 0 && if1.quarter_frame) first1 = tk;
    end
    chk("q_after_rst_d0", first0, 3729);
    chk("q_after_rst_d1", first1, 3729);

    cmp_on = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
